// File: rtl/imm_pkg.sv
// Shared decode constants for the immediate generator and the branch-predict path.
package imm_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_I   = 3'd0,
    FMT_S   = 3'd1,
    FMT_B   = 3'd2,
    FMT_U   = 3'd3,
    FMT_J   = 3'd4,
    FMT_R   = 3'd5,
    FMT_UNK = 3'd7
  } fmt_e;

  // Number of beats currently held by the stage.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  // Shift-immediates (slli/srli/srai) carry a shamt instead of a signed immediate.
  function automatic logic is_shift_imm(input logic [31:0] instr);
    return (instr[6:0] == OP_IMM) && (instr[13:12] == 2'b01);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate extractor: instruction word to extended immediate and format.
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  logic [31:0] imm32;
  logic [5:0]  shamt;

  // Every format fits in 32 bits; widening to XLEN is one signed cast at the end.
  always_comb begin
    shamt   = {(XLEN == 64) ? instr[25] : 1'b0, instr[24:20]};
    imm32   = '0;
    fmt     = FMT_UNK;
    illegal = 1'b0;
    case (instr[6:0])
      OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
        imm32 = {{20{instr[31]}}, instr[31:20]};
        fmt   = FMT_I;
      end
      OP_IMM: begin
        if (is_shift_imm(instr)) begin
          imm32 = {26'b0, shamt};
        end else begin
          imm32 = {{20{instr[31]}}, instr[31:20]};
        end
        fmt = FMT_I;
      end
      OP_STORE: begin
        imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        fmt   = FMT_S;
      end
      OP_BRANCH: begin
        imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt   = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm32 = {instr[31:12], 12'b0};
        fmt   = FMT_U;
      end
      OP_JAL: begin
        imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt   = FMT_J;
      end
      OP_REG: begin
        imm32 = '0;
        fmt   = FMT_R;
      end
      default: begin
        imm32   = '0;
        fmt     = FMT_UNK;
        illegal = 1'b1;
      end
    endcase
    imm = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered decode-stage immediate generator with valid/ready handshake and optional skid entry.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit SKID = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] target_o,
  output logic [2:0]      fmt_o,
  output logic            illegal_o
);

  logic [XLEN-1:0] dec_imm;
  logic [XLEN-1:0] dec_target;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr_i),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign dec_target = pc_i + dec_imm;

  state_e state;
  state_e state_next;

  logic accept;
  logic retire;
  logic load_main;
  logic load_skid;
  logic promote;

  logic [XLEN-1:0] main_imm;
  logic [XLEN-1:0] main_target;
  logic [2:0]      main_fmt;
  logic            main_illegal;
  logic [XLEN-1:0] skid_imm;
  logic [XLEN-1:0] skid_target;
  logic [2:0]      skid_fmt;
  logic            skid_illegal;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Without SKID, in_ready forbids accept-without-retire in ONE, so TWO is unreachable.
  always_comb begin
    state_next = state;
    if (flush_i) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state_next = ST_ONE;
        ST_ONE: begin
          if (accept && !retire) begin
            state_next = ST_TWO;
          end else if (!accept && retire) begin
            state_next = ST_EMPTY;
          end
        end
        ST_TWO:   if (retire) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  // With SKID, in_ready is a pure decode of the state flop, never of out_ready_i.
  always_comb begin
    out_valid_o = (state != ST_EMPTY);
    if (SKID) begin
      in_ready_o = (state != ST_TWO);
    end else begin
      in_ready_o = (state == ST_EMPTY) || out_ready_i;
    end
  end

  assign accept    = in_valid_i && in_ready_o;
  assign retire    = out_valid_o && out_ready_i;
  assign load_main = accept && ((state == ST_EMPTY) || ((state == ST_ONE) && retire));
  assign load_skid = accept && (state == ST_ONE) && !retire;
  assign promote   = retire && (state == ST_TWO);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      main_imm     <= '0;
      main_target  <= '0;
      main_fmt     <= '0;
      main_illegal <= 1'b0;
    end else if (load_main) begin
      main_imm     <= dec_imm;
      main_target  <= dec_target;
      main_fmt     <= dec_fmt;
      main_illegal <= dec_illegal;
    end else if (promote) begin
      main_imm     <= skid_imm;
      main_target  <= skid_target;
      main_fmt     <= skid_fmt;
      main_illegal <= skid_illegal;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      skid_imm     <= '0;
      skid_target  <= '0;
      skid_fmt     <= '0;
      skid_illegal <= 1'b0;
    end else if (load_skid) begin
      skid_imm     <= dec_imm;
      skid_target  <= dec_target;
      skid_fmt     <= dec_fmt;
      skid_illegal <= dec_illegal;
    end
  end

  assign imm_o     = main_imm;
  assign target_o  = main_target;
  assign fmt_o     = main_fmt;
  assign illegal_o = main_illegal;

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered decode-stage immediate generator with valid/ready handshake and 2-entry skid buffer.
- Covers every RV base format: I, S, B, U, J, plus R and shift-immediate.
- Parametrised in XLEN; also produces the PC-relative target (pc + imm) for branch/jump resolution.
- Sits between the IF/ID register and the ID/EX register of the pipeline CPU; replaces the purely combinational sign extender.

Parameters:
- XLEN, 32: datapath width, 32 or 64; imm_o and target_o are XLEN wide.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready_o; 0 = single register with in_ready_o = ~out_valid_o | out_ready_i.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous pipeline flush; drops all held entries.
- in_valid_i  in  1  upstream beat valid.
- in_ready_o  out  1  stage can accept a beat.
- instr_i  in  32  raw instruction.
- pc_i  in  XLEN  PC of instr_i.
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  downstream accepts.
- imm_o  out  XLEN  extended immediate.
- target_o  out  XLEN  pc + imm_o, modulo 2^XLEN.
- fmt_o  out  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=R, 7=unknown.
- illegal_o  out  1  opcode not recognised.

Behaviour:
Decode (combinational, opcode instr[6:0]):
- I format, opcodes 0000011, 0010011, 1100111, 1110011, 0001111: sext(instr[31:20]).
- S format, opcode 0100011: sext({instr[31:25], instr[11:7]}).
- B format, opcode 1100011: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
- U format, opcodes 0110111, 0010111: sext({instr[31:12], 12'b0}); XLEN=64 sign-extends from bit 31.
- J format, opcode 1101111: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
- Shift-immediate, opcode 0010011 with funct3 001/101: zero-extended shamt, instr[24:20] at XLEN=32, instr[25:20] at XLEN=64.
- R format, opcode 0110011: imm 0, fmt 5.
- Any other opcode: imm 0, fmt 7, illegal_o=1; the beat still flows through.
- target = pc_i + imm, computed before the register, truncated to XLEN.

Handshake:
- Beat accepted when in_valid_i & in_ready_o.
- Beat retired when out_valid_o & out_ready_i.
- Latency 1 cycle: a beat accepted at edge N is visible on the outputs after edge N.
- Outputs are held stable while out_valid_o & ~out_ready_i.
- Strict in-order delivery.

State (SKID=1), as count of held entries:
- EMPTY: accept -> ONE.
- ONE: accept & retire -> ONE; accept only -> TWO (new beat into skid); retire only -> EMPTY.
- TWO: retire -> ONE (skid promotes to main).
- in_ready_o is registered, = (state != TWO); it is never combinationally dependent on out_ready_i.

Flush and reset:
- flush_i=1 at an edge: state -> EMPTY regardless of accept/retire in that cycle; a beat offered that cycle is dropped; in_ready_o=1 next cycle.
- Reset (rst_i=0, any time, mid-operation included): immediately out_valid_o=0, imm_o=0, target_o=0, fmt_o=0, illegal_o=0, state EMPTY, in_ready_o=1.
- Held payload of an invalid entry is don't-care except after reset, where it is 0.

Decomposition:
- Shared package imm_pkg: opcode constants (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM, OP_FENCE, OP_REG), fmt codes FMT_I..FMT_UNK, state encoding.
- One sub-module: imm_decode, purely combinational (instr -> imm, fmt, illegal); reused by the branch-predict path.
- Skid/register logic stays in imm_gen_stage.

Test Plan:
- XLEN=32, out_ready_i=1: instr 0xFFF00093 (addi x1,x0,-1), pc 0x0 -> next cycle imm 0xFFFFFFFF, fmt 0, illegal 0.
- instr 0xFE112E23 (sw x1,-4(x2)) -> imm 0xFFFFFFFC, fmt 1. instr 0xFE000CE3 (beq -8), pc 0x100 -> imm 0xFFFFFFF8, target 0x000000F8, fmt 2.
- instr 0xFFDFF06F (jal x0,-4), pc 0x40 -> imm 0xFFFFFFFC, target 0x3C, fmt 4. instr 0x0000007F -> fmt 7, illegal 1, imm 0.
- XLEN=64: instr 0x800000B7 (lui x1,0x80000) -> imm 0xFFFFFFFF80000000. instr 0x03F0D093 (srli x1,x1,63) -> imm 63.
- Backpressure: out_ready_i=0, three back-to-back beats A, B, C -> A, B accepted, in_ready_o=0 from the cycle after B; out_ready_i=1 -> A, B, C delivered in order, no loss or duplication.
- Flush while in TWO -> out_valid_o=0 next cycle, in_ready_o=1. Reset asserted while in ONE -> outputs zero with no clock edge; first beat after release has latency 1.
